// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor now, adder later).
// State encodings are fixed so both blocks present the same handshake sequencing.
package serial_arith_pkg;

    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit subtractor cells: half_subtractor and a full_subtractor built from two of them.
// diff = a ^ b ^ bin, bout = (~a & b) | (~(a ^ b) & bin).
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs0 (
        .x  (a),
        .y  (b),
        .d  (d1),
        .bo (b1)
    );

    half_subtractor u_hs1 (
        .x  (d1),
        .y  (bin),
        .d  (diff),
        .bo (b2)
    );

    assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell and a registered borrow.
// Operands in and result out on valid/ready handshakes; one operation in flight at a time.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    // WIDTH+1 states of headroom so the terminal compare cannot wrap, even at WIDTH=1
    localparam int CW = $clog2(WIDTH + 1);

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       a_sh;
    logic [WIDTH-1:0]       b_sh;
    logic [WIDTH-1:0]       res;
    logic [WIDTH-1:0]       res_next;
    logic                   bor_ff;
    logic                   cell_d;
    logic                   cell_bo;

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (bor_ff),
        .diff (cell_d),
        .bout (cell_bo)
    );

    always_comb begin
        res_next            = res >> 1;
        res_next[WIDTH-1]   = cell_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        bor_ff   <= 1'b0;
                        res      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    bor_ff <= cell_bo;
                    res    <= res_next;
                    cnt    <= cnt + 1'b1;
                    // On the last bit a_sh[0]/b_sh[0] are the operand sign bits and cell_d the result sign
                    if (cnt == CW'(WIDTH - 1)) begin
                        diff      <= res_next;
                        borrow    <= cell_bo;
                        ovf       <= (a_sh[0] ^ b_sh[0]) & (cell_d ^ a_sh[0]);
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;

    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] diff1;
    logic       borrow1;
    logic       ovf1;

    int errors = 0;
    int checks = 0;

    logic [7:0] va  [4] = '{8'h00, 8'h5A, 8'h10, 8'h80};
    logic [7:0] vb  [4] = '{8'hFF, 8'h3C, 8'h20, 8'h01};
    logic [7:0] vd  [4] = '{8'h01, 8'h1E, 8'hF0, 8'h7F};
    logic       vbo [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .diff      (diff1),
        .borrow    (borrow1),
        .ovf       (ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb, input logic eo);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 30) begin
            step();
            w++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = ~av;
        b = ~bv;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!out_valid && lat < 30);
        chk({tag, "_latency"}, 32'(lat), 32'd8);
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        if (out_ready) begin
            step();
            chk({tag, "_consumed"}, 32'(out_valid), 32'd0);
        end
    endtask

    task automatic run_op1(input string tag, input logic av, input logic bv,
                           input logic ed, input logic eb, input logic eo);
        int w;
        int lat;
        w = 0;
        while (!in_ready1 && w < 10) begin
            step();
            w++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready1), 32'd1);
        a1 = av;
        b1 = bv;
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!out_valid1 && lat < 10);
        chk({tag, "_latency"}, 32'(lat), 32'd1);
        chk({tag, "_diff"}, 32'(diff1), 32'(ed));
        chk({tag, "_borrow"}, 32'(borrow1), 32'(eb));
        chk({tag, "_ovf"}, 32'(ovf1), 32'(eo));
        step();
        chk({tag, "_consumed"}, 32'(out_valid1), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "bench timeout");
    end

    initial begin
        int acc [4];
        int idx;
        int ridx;
        int seen;
        logic acc_now;

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a          = '0;
        b          = '0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        a1         = '0;
        b1         = '0;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_w1_in_ready", 32'(in_ready1), 32'd0);
        chk("rst_w1_out_valid", 32'(out_valid1), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // basic, borrow, signed overflow cases
        run_op("t1", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
        run_op("t2", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        run_op("t3a", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op("t3b", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // backpressure in DONE with fresh operands offered
        out_ready = 1'b0;
        run_op("t4", 8'h33, 8'h44, 8'hEF, 1'b1, 1'b0);
        a = 8'hAA;
        b = 8'h11;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_out_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_in_ready", 32'(in_ready), 32'd0);
            chk("t4_hold_diff", 32'(diff), 32'hEF);
        end
        out_ready = 1'b1;
        step();
        chk("t4_release_out_valid", 32'(out_valid), 32'd0);
        chk("t4_release_in_ready", 32'(in_ready), 32'd1);
        run_op("t4b", 8'hAA, 8'h11, 8'h99, 1'b0, 1'b0);

        // reset in the third SHIFT cycle abandons the operation
        a = 8'h5A;
        b = 8'h3C;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
        chk("t5_rst_diff", 32'(diff), 32'd0);
        rst = 1'b0;
        step();
        chk("t5_release_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen = 1;
            step();
        end
        chk("t5_no_stale_result", 32'(seen), 32'd0);
        run_op("t5b", 8'h01, 8'h01, 8'h00, 1'b0, 1'b0);

        // back-to-back with in_valid held high
        idx  = 0;
        ridx = 0;
        a = va[0];
        b = vb[0];
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 80 && ridx < 4; cyc++) begin
            acc_now = in_ready && in_valid;
            if (acc_now) acc[idx] = cyc;
            step();
            if (acc_now) begin
                idx++;
                if (idx < 4) begin
                    a = va[idx];
                    b = vb[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                chk("t6_diff", 32'(diff), 32'(vd[ridx]));
                chk("t6_borrow", 32'(borrow), 32'(vbo[ridx]));
                ridx++;
            end
        end
        in_valid = 1'b0;
        chk("t6_results", 32'(ridx), 32'd4);
        chk("t6_period01", 32'(acc[1] - acc[0]), 32'd10);
        chk("t6_period12", 32'(acc[2] - acc[1]), 32'd10);
        chk("t6_period23", 32'(acc[3] - acc[2]), 32'd10);

        // single-bit instance
        run_op1("w1_a", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        run_op1("w1_b", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op1("w1_c", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
